wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V core: holds one retiring instruction, selects its result (ALU, PC+4, or formatted load data) using the `wbsel`/`regwen`/`fp_regwen` decode, and drives the integer and FP register-file write ports. Loads stall the stage until the data-memory response arrives. Upstream (MEM stage) sees back-pressure, and the hazard unit sees a busy/pending-destination indication.

## Interface
Parameters:
- `DWIDTH`, 32, data width of all result paths.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  stage can accept; handshake fires when `in_valid & in_ready` at a rising edge.
- `in_inst`  in  32  instruction word; `rd` = [11:7], load funct3 = [14:12].
- `in_pc`  in  DWIDTH  instruction PC.
- `in_alu`  in  DWIDTH  ALU result; also the load address.
- `in_wbsel`  in  2  00 MEM, 01 ALU, 10 PC+4, 11 reserved.
- `in_regwen`  in  1  integer write requested.
- `in_fp_regwen`  in  1  FP write requested.
- `dmem_rvalid`  in  1  load data valid this cycle.
- `dmem_rdata`  in  DWIDTH  aligned 32-bit word containing the load data.
- `rf_we`, `rf_waddr` [5], `rf_wdata` [DWIDTH]  out  integer RF write port, registered.
- `fprf_we`, `fprf_waddr` [5], `fprf_wdata` [DWIDTH]  out  FP RF write port, registered.
- `wb_busy`  out  1  a load is waiting for data.
- `wb_pending_rd`  out  5  destination of the waiting load.
- `wb_pending_fp`  out  1  waiting load targets the FP file.

## Operation
- The state machine has two states: IDLE and WAIT_LOAD.
- `in_ready` = (state == IDLE). It is combinational from state only and never depends on `in_valid`.
- **IDLE, handshake, wbsel ≠ 00:**
  - Compute the result: ALU → `in_alu`; PC+4 → `in_pc + 4` with wraparound modulo 2^DWIDTH; reserved 11 → no write.
  - Register the write into the outputs. State stays IDLE.
- **IDLE, handshake, wbsel = 00:**
  - Latch `rd`, funct3, `in_alu[1:0]`, `regwen` and `fp_regwen`. Go to WAIT_LOAD.
  - `wb_busy` = 1 next cycle.
  - If the latched regwen and fp_regwen are both 0, the stage still waits for `dmem_rvalid` and then writes nothing.
- **WAIT_LOAD, `dmem_rvalid` = 1:**
  - Format the data, register the write, and return to IDLE.
  - While `dmem_rvalid` = 0, stay in WAIT_LOAD indefinitely.
- **Load formatting** by latched funct3, with `lo` = latched address[1:0]:
  - LB: `rdata[8*lo +: 8]`, sign-extended. LBU: same byte, zero-extended.
  - LH: `rdata[16*lo[1] +: 16]`, sign-extended. LHU: same halfword, zero-extended. `lo[0]` is ignored.
  - LW and any other funct3: the full word.
- **Write-enable rules:**
  - `rf_we` = regwen & !fp_regwen & (rd ≠ 0).
  - `fprf_we` = fp_regwen; `f0` is writable.
  - Both regwen and fp_regwen set: FP write only.
  - Address and data outputs carry `rd` and the result whenever the matching enable is 1. Otherwise they hold their previous values.
- `dmem_rvalid` in IDLE is ignored: no write, no state change.

## Timing
- **Reset:** state IDLE. `rf_we`, `fprf_we`, `wb_busy`, `wb_pending_fp` = 0; `rf_waddr`, `fprf_waddr`, `wb_pending_rd` = 0; both wdata = 0.
- **Reset during WAIT_LOAD:** the pending load is dropped. A `dmem_rvalid` arriving later is ignored.
- **Non-load latency:** handshake at edge N → write enable high for exactly the cycle between edges N and N+1. Throughput is one instruction per cycle.
- **Load latency:** handshake at edge N; `dmem_rvalid` sampled at edge M > N → write enable high in the cycle after M.
  - `in_ready` is 0 from N through M and returns to 1 after M.
  - The next instruction can be accepted no earlier than edge M+1.
- **Write-enable pulse:** each enable is a single-cycle pulse and deasserts automatically the next cycle unless a new write occurs.
- **Hazard outputs:** `wb_busy`, `wb_pending_rd` and `wb_pending_fp` are valid throughout WAIT_LOAD. They are 0 in IDLE.

## Test plan
- **Back-to-back non-loads.** Three consecutive handshakes: ADD x5 with alu=0x11; JAL x1 with pc=0x100; ADDI x0.
  - Required: `rf_we` pulses with (5, 0x11), then (1, 0x104); no write for x0; `in_ready` stays 1 throughout.
- **LB with a 3-cycle response delay.** rdata=0x80FF7F01, addr_lo=3, rd=x7.
  - Required: `in_ready` = 0 and `wb_busy` = 1 with pending_rd=7 until rvalid; then x7 ← 0xFFFFFF80.
- **LHU/LH sweep.** rdata=0x8001FFFE.
  - LHU lo=2 → 0x00008001. LH lo=0 → 0xFFFFFFFE. LH lo=1 → 0xFFFFFFFE.
- **FP load.** fp_regwen=1, rd=0, rdata=0x3F800000.
  - Required: `fprf_we` with (0, 0x3F800000); `rf_we` stays 0.
- **Reset during WAIT_LOAD, then a late response.** Assert `rst` while waiting, then drive `dmem_rvalid` two cycles later.
  - Required: no write; state IDLE with `in_ready` = 1; all outputs at reset values.
- **Stray response.** `dmem_rvalid` pulse in IDLE with no load outstanding.
  - Required: no write and no change to `in_ready`.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V writeback stage with load-response wait and RF write ports
//
// Holds one retiring instruction. Non-load results (ALU, PC+4) are written
// the cycle after the handshake. Loads park the stage in WAIT_LOAD until the
// data-memory response arrives, then the formatted load data is written.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid / in_ready             MEM-stage handshake (in_ready = stage idle)
//   in_inst, in_pc, in_alu          instruction word, PC, ALU result / load address
//   in_wbsel, in_regwen, in_fp_regwen  result select and write-enable decode
//   dmem_rvalid, dmem_rdata         data-memory load response
//   rf_we/rf_waddr/rf_wdata         integer register-file write port (registered)
//   fprf_we/fprf_waddr/fprf_wdata   FP register-file write port (registered)
//   wb_busy, wb_pending_rd, wb_pending_fp  hazard indication for the waiting load

module wb_stage #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DWIDTH-1:0] in_pc,
    input  logic [DWIDTH-1:0] in_alu,
    input  logic [1:0]        in_wbsel,
    input  logic              in_regwen,
    input  logic              in_fp_regwen,
    input  logic              dmem_rvalid,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DWIDTH-1:0] rf_wdata,
    output logic              fprf_we,
    output logic [4:0]        fprf_waddr,
    output logic [DWIDTH-1:0] fprf_wdata,
    output logic              wb_busy,
    output logic [4:0]        wb_pending_rd,
    output logic              wb_pending_fp
);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lo;
    logic        r_regwen;
    logic        r_fp_regwen;

    logic [4:0]        w_in_rd;
    logic [DWIDTH-1:0] w_alu_res;
    logic [DWIDTH-1:0] w_load_res;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_unused_inst;

    assign in_ready      = (r_state == S_IDLE);
    assign w_in_rd       = in_inst[11:7];
    assign w_unused_inst = ^{in_inst[31:15], in_inst[6:0]};

    // Only wbsel 01 and 10 reach this path; 11 is filtered out before writing.
    assign w_alu_res = (in_wbsel == 2'b01) ? in_alu : (in_pc + DWIDTH'(4));

    // Byte lane picked by both address bits, halfword lane by bit 1 only.
    assign w_byte = dmem_rdata[{r_lo, 3'b000} +: 8];
    assign w_half = dmem_rdata[{r_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_load_res = dmem_rdata;
        case (r_funct3)
            3'b000:  w_load_res = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_res = {{(DWIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load_res = {{(DWIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load_res = {{(DWIDTH-16){1'b0}}, w_half};
            default: w_load_res = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rd          <= '0;
            r_funct3      <= '0;
            r_lo          <= '0;
            r_regwen      <= 1'b0;
            r_fp_regwen   <= 1'b0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            fprf_we       <= 1'b0;
            fprf_waddr    <= '0;
            fprf_wdata    <= '0;
            wb_busy       <= 1'b0;
            wb_pending_rd <= '0;
            wb_pending_fp <= 1'b0;
        end else begin
            // Enables are single-cycle pulses; addr/data hold otherwise.
            rf_we   <= 1'b0;
            fprf_we <= 1'b0;
            if (r_state == S_IDLE) begin
                if (in_valid) begin
                    if (in_wbsel == 2'b00) begin
                        r_rd          <= w_in_rd;
                        r_funct3      <= in_inst[14:12];
                        r_lo          <= in_alu[1:0];
                        r_regwen      <= in_regwen;
                        r_fp_regwen   <= in_fp_regwen;
                        r_state       <= S_WAIT_LOAD;
                        wb_busy       <= 1'b1;
                        wb_pending_rd <= w_in_rd;
                        wb_pending_fp <= in_fp_regwen;
                    end else if (in_wbsel != 2'b11) begin
                        // FP decode wins when both enables are set.
                        if (in_fp_regwen) begin
                            fprf_we    <= 1'b1;
                            fprf_waddr <= w_in_rd;
                            fprf_wdata <= w_alu_res;
                        end else if (in_regwen && (w_in_rd != 5'd0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= w_in_rd;
                            rf_wdata <= w_alu_res;
                        end
                    end
                end
            end else if (dmem_rvalid) begin
                if (r_fp_regwen) begin
                    fprf_we    <= 1'b1;
                    fprf_waddr <= r_rd;
                    fprf_wdata <= w_load_res;
                end else if (r_regwen && (r_rd != 5'd0)) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= r_rd;
                    rf_wdata <= w_load_res;
                end
                r_state       <= S_IDLE;
                wb_busy       <= 1'b0;
                wb_pending_rd <= '0;
                wb_pending_fp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage

module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [1:0]  in_wbsel;
    logic        in_regwen;
    logic        in_fp_regwen;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fprf_we;
    logic [4:0]  fprf_waddr;
    logic [31:0] fprf_wdata;
    logic        wb_busy;
    logic [4:0]  wb_pending_rd;
    logic        wb_pending_fp;

    always #5 clk = ~clk;

    wb_stage #(.DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_alu(in_alu),
        .in_wbsel(in_wbsel), .in_regwen(in_regwen), .in_fp_regwen(in_fp_regwen),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fprf_we(fprf_we), .fprf_waddr(fprf_waddr), .fprf_wdata(fprf_wdata),
        .wb_busy(wb_busy), .wb_pending_rd(wb_pending_rd), .wb_pending_fp(wb_pending_fp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [2:0]  m_f3 = '0;
    logic [1:0]  m_lo = '0;
    bit          m_rw = 1'b0;
    bit          m_fw = 1'b0;
    logic        e_rf_we = 1'b0, e_fp_we = 1'b0;
    logic [4:0]  e_rf_a = '0, e_fp_a = '0;
    logic [31:0] e_rf_d = '0, e_fp_d = '0;

    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic mwrite(input logic [4:0] rd, input bit rw, input bit fw, input logic [31:0] d);
        if (fw) begin
            e_fp_we = 1'b1; e_fp_a = rd; e_fp_d = d;
        end else if (rw && rd != 0) begin
            e_rf_we = 1'b1; e_rf_a = rd; e_rf_d = d;
        end
    endtask

    always @(posedge clk) begin
        e_rf_we = 1'b0;
        e_fp_we = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            e_rf_a = '0; e_rf_d = '0; e_fp_a = '0; e_fp_d = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                if (in_wbsel == 2'd0) begin
                    m_busy = 1'b1;
                    m_rd = in_inst[11:7]; m_f3 = in_inst[14:12]; m_lo = in_alu[1:0];
                    m_rw = in_regwen; m_fw = in_fp_regwen;
                end else if (in_wbsel == 2'd1) begin
                    mwrite(in_inst[11:7], in_regwen, in_fp_regwen, in_alu);
                end else if (in_wbsel == 2'd2) begin
                    mwrite(in_inst[11:7], in_regwen, in_fp_regwen, in_pc + 32'd4);
                end
            end
        end else if (dmem_rvalid) begin
            mwrite(m_rd, m_rw, m_fw, fmt(dmem_rdata, m_f3, m_lo));
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready",   in_ready,      !m_busy);
            check("wb_busy",    wb_busy,       m_busy);
            check("pending_rd", wb_pending_rd, m_busy ? m_rd : 5'd0);
            check("pending_fp", wb_pending_fp, m_busy ? m_fw : 1'b0);
            check("rf_we",      rf_we,         e_rf_we);
            check("rf_waddr",   rf_waddr,      e_rf_a);
            check("rf_wdata",   rf_wdata,      e_rf_d);
            check("fprf_we",    fprf_we,       e_fp_we);
            check("fprf_waddr", fprf_waddr,    e_fp_a);
            check("fprf_wdata", fprf_wdata,    e_fp_d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] wbsel, input logic rw, input logic fw,
                         input logic [31:0] pc, input logic [31:0] alu);
        in_valid = 1'b1;
        in_inst = {17'h0, 3'b000, rd, 7'h33};
        in_wbsel = wbsel; in_regwen = rw; in_fp_regwen = fw;
        in_pc = pc; in_alu = alu;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic rw, input logic fw, input logic [31:0] data, input int delay);
        in_valid = 1'b1;
        in_inst = {17'h0, f3, rd, 7'h03};
        in_alu = {30'h400, lo};
        in_wbsel = 2'b00; in_regwen = rw; in_fp_regwen = fw;
        tick();
        in_valid = 1'b0;
        check("ld_ready_low", in_ready, 1'b0);
        check("ld_busy", wb_busy, 1'b1);
        check("ld_pend_rd", wb_pending_rd, rd);
        repeat (delay - 1) begin
            tick();
            check("ld_wait_ready", in_ready, 1'b0);
        end
        dmem_rvalid = 1'b1; dmem_rdata = data;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'hDEADBEEF;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_alu = '0;
        in_wbsel = 2'b01; in_regwen = 1'b0; in_fp_regwen = 1'b0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_rf_wdata", rf_wdata, 32'h0);
        check("rst_fp_wdata", fprf_wdata, 32'h0);
        check("rst_busy", wb_busy, 1'b0);
        rst = 1'b0;

        // Back-to-back non-loads
        issue(5'd5, 2'b01, 1'b1, 1'b0, 32'h0, 32'h11);
        tick();
        check("add_we", rf_we, 1'b1); check("add_a", rf_waddr, 5'd5); check("add_d", rf_wdata, 32'h11);
        check("b2b_ready1", in_ready, 1'b1);
        issue(5'd1, 2'b10, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        check("jal_we", rf_we, 1'b1); check("jal_a", rf_waddr, 5'd1); check("jal_d", rf_wdata, 32'h104);
        issue(5'd0, 2'b01, 1'b1, 1'b0, 32'h0, 32'h55);
        tick();
        check("x0_we", rf_we, 1'b0); check("x0_hold", rf_wdata, 32'h104);
        check("b2b_ready3", in_ready, 1'b1);

        // Reserved wbsel, dual-enable non-load, PC+4 wraparound
        issue(5'd3, 2'b11, 1'b1, 1'b0, 32'h0, 32'h77);
        tick();
        check("rsv_we", rf_we, 1'b0);
        issue(5'd4, 2'b01, 1'b1, 1'b1, 32'h0, 32'h1234);
        tick();
        check("dual_fp_we", fprf_we, 1'b1); check("dual_fp_d", fprf_wdata, 32'h1234);
        check("dual_rf_we", rf_we, 1'b0);
        issue(5'd2, 2'b10, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0);
        tick();
        in_valid = 1'b0;
        check("wrap_d", rf_wdata, 32'h2);

        // LB with 3-cycle response
        do_load(5'd7, 3'd0, 2'd3, 1'b1, 1'b0, 32'h80FF7F01, 3);
        check("lb_we", rf_we, 1'b1); check("lb_a", rf_waddr, 5'd7); check("lb_d", rf_wdata, 32'hFFFFFF80);
        check("lb_ready", in_ready, 1'b1);

        // LHU/LH sweep
        do_load(5'd8, 3'd5, 2'd2, 1'b1, 1'b0, 32'h8001FFFE, 1);
        check("lhu2_d", rf_wdata, 32'h00008001);
        do_load(5'd9, 3'd1, 2'd0, 1'b1, 1'b0, 32'h8001FFFE, 1);
        check("lh0_d", rf_wdata, 32'hFFFFFFFE);
        do_load(5'd10, 3'd1, 2'd1, 1'b1, 1'b0, 32'h8001FFFE, 1);
        check("lh1_d", rf_wdata, 32'hFFFFFFFE);

        // FP load into f0
        do_load(5'd0, 3'd2, 2'd0, 1'b0, 1'b1, 32'h3F800000, 2);
        check("fld_we", fprf_we, 1'b1); check("fld_a", fprf_waddr, 5'd0);
        check("fld_d", fprf_wdata, 32'h3F800000); check("fld_rf_we", rf_we, 1'b0);

        // Load with no enables still waits, writes nothing
        do_load(5'd11, 3'd2, 2'd0, 1'b0, 1'b0, 32'h0000CAFE, 2);
        check("noen_rf_we", rf_we, 1'b0); check("noen_fp_we", fprf_we, 1'b0);

        // Reset during WAIT_LOAD then late response
        in_valid = 1'b1; in_inst = {17'h0, 3'd2, 5'd9, 7'h03}; in_alu = 32'h1000;
        in_wbsel = 2'b00; in_regwen = 1'b1; in_fp_regwen = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        check("rstw_rf_we", rf_we, 1'b0); check("rstw_fp_we", fprf_we, 1'b0);
        check("rstw_ready", in_ready, 1'b1); check("rstw_busy", wb_busy, 1'b0);
        check("rstw_rf_a", rf_waddr, 5'd0); check("rstw_rf_d", rf_wdata, 32'h0);
        check("rstw_fp_d", fprf_wdata, 32'h0); check("rstw_pend", wb_pending_rd, 5'd0);

        // Stray response in IDLE
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF0000;
        tick();
        dmem_rvalid = 1'b0;
        check("stray_we", rf_we, 1'b0); check("stray_ready", in_ready, 1'b1);
        issue(5'd6, 2'b01, 1'b1, 1'b0, 32'h0, 32'hAB);
        tick();
        in_valid = 1'b0;
        check("post_a", rf_waddr, 5'd6); check("post_d", rf_wdata, 32'hAB);

        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
